// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between the PCI host path
// and user logic; tracks one outstanding read with a timeout.
module mem_req_arbiter #(
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pci_req,
    input  logic              pci_wr,
    input  logic [ADDR_W-1:0] pci_addr,
    input  logic [DATA_W-1:0] pci_wdata,
    output logic              pci_gnt,
    output logic              pci_rvalid,
    output logic [DATA_W-1:0] pci_rdata,
    input  logic              usr_req,
    input  logic              usr_wr,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_wdata,
    output logic              usr_gnt,
    output logic              usr_rvalid,
    output logic [DATA_W-1:0] usr_rdata,
    output logic              mem_req,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rd_ready,
    output logic              rd_timeout,
    output logic [7:0]        timeout_cnt
);

    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             grant_pci;
    logic             grant_usr;
    logic             rd_done;
    logic             rd_expire;
    logic             last_usr;
    logic             owner_usr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Arbitration and read completion; grants exist only in IDLE.
    always_comb begin
        next_state = state;
        grant_pci  = 1'b0;
        grant_usr  = 1'b0;
        rd_done    = 1'b0;
        rd_expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_usr = usr_req && (!pci_req || !last_usr);
                grant_pci = pci_req && !grant_usr;
                if (grant_pci || grant_usr) next_state = ST_ISSUE;
            end
            ST_ISSUE: next_state = mem_wr_en ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem_rd_ready) begin
                    rd_done    = 1'b1;
                    next_state = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    rd_expire  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign pci_gnt = grant_pci;
    assign usr_gnt = grant_usr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_usr    <= 1'b1;
            owner_usr   <= 1'b0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            pci_rvalid  <= 1'b0;
            pci_rdata   <= '0;
            usr_rvalid  <= 1'b0;
            usr_rdata   <= '0;
            rd_timeout  <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            mem_req    <= 1'b0;
            pci_rvalid <= 1'b0;
            usr_rvalid <= 1'b0;
            rd_timeout <= 1'b0;

            // mem_wr_en doubles as the latched command type while in ISSUE.
            if (grant_pci || grant_usr) begin
                owner_usr <= grant_usr;
                last_usr  <= grant_usr;
                mem_req   <= 1'b1;
                mem_wr_en <= grant_usr ? usr_wr    : pci_wr;
                mem_addr  <= grant_usr ? usr_addr  : pci_addr;
                mem_wdata <= grant_usr ? usr_wdata : pci_wdata;
            end else if (state == ST_ISSUE) begin
                mem_wr_en <= 1'b0;
            end

            if (state == ST_ISSUE)
                cnt <= '0;
            else if (state == ST_RD_WAIT && !mem_rd_ready)
                cnt <= cnt + CNT_W'(1);

            if (rd_done) begin
                if (owner_usr) begin
                    usr_rdata  <= mem_rdata;
                    usr_rvalid <= 1'b1;
                end else begin
                    pci_rdata  <= mem_rdata;
                    pci_rvalid <= 1'b1;
                end
            end

            if (rd_expire) begin
                rd_timeout <= 1'b1;
                if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single on-board memory request port between two requesters: the PCI host path and the user FPGA logic.
- Arbitrates round-robin on contention and registers the winning command onto the memory port.
- Tracks one outstanding read, routes the returned data back to its owner, and times out a read whose data never returns.
- Sits between the PCI bridge / user core and the memory controller's rd_req / FPGA_wr_en / req_addr / write_data / rd_data / rd_ready interface.

Parameters:
- ADDR_W, 21, memory word address width
- DATA_W, 32, data width
- RD_TIMEOUT, 256, cycles in RD_WAIT without rd_ready before the read is abandoned (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pci_req  in  1  PCI requests an access; held with fields stable until pci_gnt
- pci_wr  in  1  1 = write, 0 = read
- pci_addr  in  ADDR_W  PCI address
- pci_wdata  in  DATA_W  PCI write data
- pci_gnt  out  1  one-cycle accept pulse
- pci_rvalid  out  1  one-cycle pulse: pci_rdata valid
- pci_rdata  out  DATA_W  read data to PCI
- usr_req, usr_wr, usr_addr, usr_wdata  in  1/1/ADDR_W/DATA_W  user side, same rules as PCI
- usr_gnt, usr_rvalid  out  1  user side, same rules as PCI
- usr_rdata  out  DATA_W  user side, same rules as PCI
- mem_req  out  1  command strobe to memory (rd_req)
- mem_wr_en  out  1  write qualifier (FPGA_wr_en)
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data from memory
- mem_rd_ready  in  1  read data valid
- rd_timeout  out  1  one-cycle pulse when a read is abandoned
- timeout_cnt  out  8  saturating count of timeouts

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours PCI, timeout_cnt 0, owner cleared.
  - Asserting reset mid-operation aborts it; no late rvalid is produced.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - With any req asserted, the winner's gnt is asserted combinationally that cycle.
  - wr/addr/wdata and the owner are latched; next state is ISSUE.
  - If only one requester asserts, it wins.
  - If both assert, the requester not granted last wins, and the pointer updates on every grant.
  - Consequence: with both continuously requesting, grants strictly alternate. A lone requester is granted back-to-back with no forced gaps.
- ISSUE (exactly 1 cycle):
  - mem_req=1, mem_wr_en=latched wr, mem_addr/mem_wdata=latched values (registered outputs).
  - Write: next state IDLE. Minimum write cadence is 2 cycles per access.
  - Read: next state RD_WAIT; the timeout counter is cleared.
- RD_WAIT:
  - mem_req=0.
  - On mem_rd_ready: mem_rdata is registered into the owner's rdata, and the owner's rvalid pulses on the following cycle. Next state IDLE.
  - New arbitration can occur in that same following cycle.
  - Non-owner rdata holds its prior value.
  - The counter increments every cycle without mem_rd_ready.
  - On reaching RD_TIMEOUT-1 with no rd_ready:
    - rd_timeout pulses the next cycle.
    - timeout_cnt increments, saturating at 255.
    - No rvalid is issued; next state IDLE.
  - If rd_ready and the timeout coincide in the same cycle, rd_ready wins (data delivered, no timeout).
- mem_rd_ready in IDLE or ISSUE (stray or late) is ignored.
- A requester must not drop req before gnt. Dropping it is a protocol violation; behaviour is defined only as "no grant issued that cycle".
- Req held after gnt is treated as a new request.
- Outputs other than gnt are registered; gnt is combinational from IDLE state and req inputs only.

Test Plan:
- PCI write 0x1FFFFE/0x00000002, user idle -> pci_gnt in cycle 0. Cycle 1: mem_req=1, mem_wr_en=1, mem_addr=0x1FFFFE, mem_wdata=0x00000002. Cycle 2: IDLE.
- Both request continuously from reset (user: writes to 0x000010+) -> grant order PCI, user, PCI, user. Each grant is 2 cycles apart; mem_addr alternates between sources accordingly.
- User read of 0x000005; mem_rd_ready with 0xDEADBEEF 3 cycles after ISSUE -> usr_rvalid=1 and usr_rdata=0xDEADBEEF one cycle later. pci_rvalid stays 0.
- PCI read with no mem_rd_ready, RD_TIMEOUT=8 -> rd_timeout pulse 8 cycles after entering RD_WAIT. timeout_cnt=1; no pci_rvalid. A user request waiting meanwhile is granted in the next IDLE.
- mem_rd_ready on the exact timeout cycle -> rvalid delivered, no rd_timeout, timeout_cnt unchanged.
- rst_n low during RD_WAIT, then mem_rd_ready after release -> no rvalid; all outputs 0; next simultaneous request is granted to PCI.
